// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, FSM state codes,
// datapath select codes, the control strobe bundle and the opcode classifier.
package cpu_defs;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDI  = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b010000;
   localparam logic [5:0] OP_AND   = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLT   = 6'b100110;
   localparam logic [5:0] OP_SLTIU = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   // The eight working states fill the 3-bit debug code; sHALT lives on bit 3,
   // so it reads 000 on the debug port and is told apart from sIF by InsMemRW = 0.
   typedef enum logic [3:0] {
      S_IF     = 4'b0000,
      S_ID     = 4'b0001,
      S_EXE_LS = 4'b0010,
      S_MEM    = 4'b0011,
      S_WB_LD  = 4'b0100,
      S_EXE_BR = 4'b0101,
      S_EXE_AL = 4'b0110,
      S_WB_AL  = 4'b0111,
      S_HALT   = 4'b1000
   } state_t;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_SLTU = 3'b010;
   localparam logic [2:0] ALU_SLT  = 3'b011;
   localparam logic [2:0] ALU_SLL  = 3'b100;
   localparam logic [2:0] ALU_OR   = 3'b101;
   localparam logic [2:0] ALU_AND  = 3'b110;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_RS     = 2'b10;
   localparam logic [1:0] PC_JUMP   = 2'b11;

   localparam logic [1:0] RD_R31 = 2'b00;
   localparam logic [1:0] RD_RT  = 2'b01;
   localparam logic [1:0] RD_RD  = 2'b10;

   typedef enum logic [3:0] {
      C_R, C_I, C_BEQ, C_LD, C_ST, C_J, C_JAL, C_JR, C_HALT, C_NOP
   } op_class_t;

   typedef struct packed {
      logic       pc_wre;
      logic       ir_wre;
      logic       ins_mem_rw;
      logic       reg_wre;
      logic [1:0] reg_dst;
      logic       wr_reg_d_src;
      logic       alu_src_a;
      logic       alu_src_b;
      logic [2:0] alu_op;
      logic       ext_sel;
      logic       m_rd;
      logic       m_wr;
      logic       db_data_src;
      logic [1:0] pc_src;
   } ctrl_t;

   function automatic op_class_t op_class(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT: return C_R;
         OP_ADDI, OP_ORI, OP_SLTIU:                     return C_I;
         OP_BEQ:  return C_BEQ;
         OP_LW:   return C_LD;
         OP_SW:   return C_ST;
         OP_J:    return C_J;
         OP_JAL:  return C_JAL;
         OP_JR:   return C_JR;
         OP_HALT: return C_HALT;
         default: return C_NOP;
      endcase
   endfunction

   function automatic logic [2:0] alu_op_of(input logic [5:0] op);
      case (op)
         OP_SUB:   return ALU_SUB;
         OP_OR,
         OP_ORI:   return ALU_OR;
         OP_AND:   return ALU_AND;
         OP_SLL:   return ALU_SLL;
         OP_SLT:   return ALU_SLT;
         OP_SLTIU: return ALU_SLTU;
         default:  return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_unit_decode.sv
// Pure combinational decode of (state, opcode, zero) into the datapath strobes.
module control_decode
   import cpu_defs::*;
#(
   parameter int OPW = 6
) (
   input  state_t         state_i,
   input  logic [OPW-1:0] opcode_i,
   input  logic           zero_i,
   output ctrl_t          ctrl_o
);

   op_class_t cls;

   assign cls = op_class(opcode_i);

   // NOTE: every field gets a default before the case, so no path leaves a latch.
   always_comb begin
      ctrl_o         = '0;
      ctrl_o.ext_sel = !(opcode_i == OP_ORI || opcode_i == OP_SLTIU);
      unique case (state_i)
         S_IF: begin
            ctrl_o.ins_mem_rw = 1'b1;
            ctrl_o.ir_wre     = 1'b1;
         end
         S_ID: begin
            case (cls)
               C_J: begin
                  ctrl_o.pc_wre = 1'b1;
                  ctrl_o.pc_src = PC_JUMP;
               end
               C_JAL: begin
                  ctrl_o.pc_wre       = 1'b1;
                  ctrl_o.pc_src       = PC_JUMP;
                  ctrl_o.reg_wre      = 1'b1;
                  ctrl_o.reg_dst      = RD_R31;
                  ctrl_o.wr_reg_d_src = 1'b0;
               end
               C_JR: begin
                  ctrl_o.pc_wre = 1'b1;
                  ctrl_o.pc_src = PC_RS;
               end
               C_NOP: begin
                  ctrl_o.pc_wre = 1'b1;
                  ctrl_o.pc_src = PC_SEQ;
               end
               default: ;
            endcase
         end
         S_EXE_AL: begin
            ctrl_o.alu_op    = alu_op_of(opcode_i);
            ctrl_o.alu_src_a = (opcode_i == OP_SLL);
            ctrl_o.alu_src_b = (cls == C_I);
         end
         S_WB_AL: begin
            ctrl_o.reg_wre      = 1'b1;
            ctrl_o.wr_reg_d_src = 1'b1;
            ctrl_o.reg_dst      = (cls == C_R) ? RD_RD : RD_RT;
            ctrl_o.pc_wre       = 1'b1;
         end
         S_EXE_BR: begin
            ctrl_o.alu_op = ALU_SUB;
            ctrl_o.pc_wre = 1'b1;
            ctrl_o.pc_src = zero_i ? PC_BRANCH : PC_SEQ;
         end
         S_EXE_LS: begin
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.alu_src_b = 1'b1;
         end
         S_MEM: begin
            if (cls == C_ST) begin
               ctrl_o.m_wr   = 1'b1;
               ctrl_o.pc_wre = 1'b1;
            end else if (cls == C_LD) begin
               ctrl_o.m_rd = 1'b1;
            end
         end
         S_WB_LD: begin
            ctrl_o.m_rd         = 1'b1;
            ctrl_o.db_data_src  = 1'b1;
            ctrl_o.reg_wre      = 1'b1;
            ctrl_o.reg_dst      = RD_RT;
            ctrl_o.wr_reg_d_src = 1'b1;
            ctrl_o.pc_wre       = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: holds the state register and next-state logic,
// and gates the write enables off while Reset is held.
module multicycle_control_unit
   import cpu_defs::*;
#(
   parameter int OPW    = 6,
   parameter int ALUOPW = 3
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [OPW-1:0]    opcode,
   input  logic              zero,
   output logic              PCWre,
   output logic              IRWre,
   output logic              InsMemRW,
   output logic              RegWre,
   output logic [1:0]        RegDst,
   output logic              WrRegDSrc,
   output logic              ALUSrcA,
   output logic              ALUSrcB,
   output logic [ALUOPW-1:0] ALUOp,
   output logic              ExtSel,
   output logic              mRD,
   output logic              mWR,
   output logic              DBDataSrc,
   output logic [1:0]        PCSrc,
   output logic [2:0]        state
);

   state_t    state_q, state_d;
   op_class_t cls;
   ctrl_t     ctrl;

   assign cls = op_class(opcode);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            case (cls)
               C_J, C_JAL, C_JR, C_NOP: state_d = S_IF;
               C_HALT:                  state_d = S_HALT;
               C_BEQ:                   state_d = S_EXE_BR;
               C_LD, C_ST:              state_d = S_EXE_LS;
               default:                 state_d = S_EXE_AL;
            endcase
         end
         S_EXE_AL: state_d = S_WB_AL;
         S_EXE_LS: state_d = S_MEM;
         S_MEM:    state_d = (cls == C_LD) ? S_WB_LD : S_IF;
         S_HALT:   state_d = S_HALT;
         S_WB_AL, S_EXE_BR, S_WB_LD: state_d = S_IF;
         default:  state_d = S_IF;
      endcase
   end

   // NOTE: state flops use non-blocking assignment so they all sample pre-edge values.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state_q <= S_IF;
      else       state_q <= state_d;
   end

   control_decode #(.OPW(OPW)) u_decode (
      .state_i  (state_q),
      .opcode_i (opcode),
      .zero_i   (zero),
      .ctrl_o   (ctrl)
   );

   // State already reads sIF during reset; the write enables must stay quiet too.
   assign PCWre     = ctrl.pc_wre  & ~Reset;
   assign IRWre     = ctrl.ir_wre  & ~Reset;
   assign RegWre    = ctrl.reg_wre & ~Reset;
   assign mWR       = ctrl.m_wr    & ~Reset;
   assign InsMemRW  = ctrl.ins_mem_rw;
   assign RegDst    = ctrl.reg_dst;
   assign WrRegDSrc = ctrl.wr_reg_d_src;
   assign ALUSrcA   = ctrl.alu_src_a;
   assign ALUSrcB   = ctrl.alu_src_b;
   assign ALUOp     = ctrl.alu_op;
   assign ExtSel    = ctrl.ext_sel;
   assign mRD       = ctrl.m_rd;
   assign DBDataSrc = ctrl.db_data_src;
   assign PCSrc     = ctrl.pc_src;
   assign state     = state_q[2:0];

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle CPU control FSM: consumer side of the instruction register.
- Drives IRWre so the instruction register latches the fetched word. Reads the latched opcode back and sequences IF -> ID -> EXE -> MEM -> WB.
- Emits every datapath control strobe: PC, register file, ALU, data memory and mux selects.
- Sits between the instruction register output and the datapath.

Parameters:
- OPW, 6, opcode width, taken from instruction bits [31:26].
- ALUOPW, 3, ALU operation select width.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- opcode  in  OPW  instruction register output bits [31:26].
- zero  in  1  ALU zero flag, valid in EXE.
- PCWre  out  1  PC write enable.
- IRWre  out  1  instruction register write enable.
- InsMemRW  out  1  instruction memory read strobe.
- RegWre  out  1  register file write enable.
- RegDst  out  2  write-register select: 00 = $31, 01 = rt, 10 = rd.
- WrRegDSrc  out  1  write data select: 0 = PC+4 (jal), 1 = DB bus.
- ALUSrcA  out  1  ALU A input: 1 = sa (shift amount, sll), 0 = rs.
- ALUSrcB  out  1  ALU B input: 1 = extended immediate, 0 = rt.
- ALUOp  out  ALUOPW  ALU operation: 000 add, 001 sub, 010 slt-unsigned, 011 slt-signed, 100 sll, 101 or, 110 and.
- ExtSel  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- DBDataSrc  out  1  DB bus source: 0 = ALU result, 1 = data memory.
- PCSrc  out  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target.
- state  out  3  current state, for debug and verification.

Behaviour:
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, sltiu 100111, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
- Any other opcode is a NOP.
- State register: asynchronous reset to sIF. It is the only flop in the block.
- All outputs are combinational decode of (state, opcode, zero).
- While Reset = 1, PCWre, IRWre, RegWre and mWR are forced to 0.
- States:
  - sIF: InsMemRW = 1, IRWre = 1; next state sID.
  - sID:
    - j, jal, jr, NOP: PCWre = 1, PCSrc = 11 / 11 / 10 / 00; next state sIF.
    - jal additionally: RegWre = 1, RegDst = 00, WrRegDSrc = 0.
    - halt: next state sHALT, PCWre = 0.
    - beq: next state sEXE_BR.
    - sw, lw: next state sEXE_LS.
    - All others: next state sEXE_AL.
  - sEXE_AL: ALU operands and ALUOp per opcode; next state sWB_AL.
  - sWB_AL:
    - RegWre = 1, DBDataSrc = 0, WrRegDSrc = 1.
    - RegDst = 10 for R-type, 01 for I-type.
    - PCWre = 1, PCSrc = 00; next state sIF.
  - sEXE_BR: ALUOp = 001 (sub), ALUSrcB = 0, ExtSel = 1; PCWre = 1, PCSrc = zero ? 01 : 00; next state sIF.
  - sEXE_LS: ALUOp = 000, ALUSrcB = 1, ExtSel = 1; next state sMEM.
  - sMEM:
    - sw: mWR = 1, PCWre = 1, PCSrc = 00; next state sIF.
    - lw: mRD = 1; next state sWB_LD.
  - sWB_LD: mRD = 1, DBDataSrc = 1, RegWre = 1, RegDst = 01, WrRegDSrc = 1; PCWre = 1, PCSrc = 00; next state sIF.
  - sHALT: all enables 0; stays until Reset.
- ExtSel per opcode: 0 for ori and sltiu, 1 otherwise.
- ALUSrcA = 1 only for sll.
- Default value of every strobe is 0 in every state where it is not listed.
- Latency per instruction class:
  - j / jr / jal / NOP: 2 cycles.
  - beq: 3 cycles.
  - ALU ops and sw: 4 cycles.
  - lw: 5 cycles.
- Exactly one PCWre pulse per retired instruction. IRWre is asserted only in sIF.
- opcode is sampled from sID onward. The IR does not change outside sIF, so opcode is stable through the instruction.
- Reset mid-instruction: returns to sIF immediately. No write strobe is asserted during reset or in the cycle after release unless sIF requires it.

Decomposition:
- Shared package cpu_defs:
  - Opcode constants (OP_ADD, ..., OP_HALT).
  - State encodings: sIF = 000, sID = 001, sEXE_AL = 110, sWB_AL = 111, sEXE_BR = 101, sEXE_LS = 010, sMEM = 011, sWB_LD = 100, sHALT fixed separately in the package.
  - ALUOp codes, PCSrc codes, RegDst codes.
- One sub-module, control_decode: pure combinational (state, opcode, zero) -> strobes.
- The top level holds only the state register and the next-state logic.

Test Plan:
- Reset asserted mid-sEXE_AL -> state = sIF immediately. RegWre = 0 and PCWre = 0 while held. IRWre = 1 on the first cycle after release.
- add (000000) -> states IF, ID, EXE_AL, WB_AL over 4 cycles. RegWre = 1 and RegDst = 10 in WB_AL only. One PCWre pulse with PCSrc = 00.
- beq with zero = 1, then with zero = 0 -> 3 cycles each. PCSrc = 01 vs 00 in sEXE_BR. RegWre never asserted.
- lw (110001) then sw (110000) -> lw takes 5 cycles: mRD in sMEM and sWB_LD, RegWre only in sWB_LD. sw takes 4 cycles: mWR = 1 only in sMEM.
- jal (111010) -> 2 cycles. In sID: RegWre = 1, RegDst = 00, WrRegDSrc = 0, PCSrc = 11, PCWre = 1.
- halt (111111) -> enters sHALT. PCWre and IRWre stay 0 for 20 cycles. Reset returns the FSM to sIF.
